safecrack_lockout_ctrl: RTL and testbench

Lockout controller that sits beside the safe's combination FSM. It counts failed attempts reported by the FSM and, after `MAX_ERRORS` failures, locks the keypad for `LOCK_SECONDS` seconds. At the end of the lockout it issues a one-cycle clear that returns the FSM to its initial state. It also drives the error-count and seconds-elapsed LED banks.

---
 rtl/safecrack_lockout_ctrl.sv | 119 +++++++++++
 tb/tb_safecrack_lockout_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/safecrack_lockout_ctrl.sv
// rtl/safecrack_lockout_ctrl.sv - failed-attempt counter with timed keypad lockout
module safecrack_lockout_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_ERRORS    = 3,
  parameter int LOCK_SECONDS  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              attempt_fail,
  input  logic                              attempt_ok,
  input  logic                              clear_errs,
  output logic                              locked,
  output logic                              fsm_clear,
  output logic [$clog2(MAX_ERRORS+1)-1:0]   err_count,
  output logic [MAX_ERRORS-1:0]             leds_erros,
  output logic [LOCK_SECONDS-1:0]           leds_segundos
);

  localparam int EW = $clog2(MAX_ERRORS + 1);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int SW = $clog2(LOCK_SECONDS + 1);

  localparam logic [EW-1:0] ERR_MAX    = EW'(MAX_ERRORS);
  localparam logic [EW-1:0] ERR_LAST   = EW'(MAX_ERRORS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SEC_MAX    = SW'(LOCK_SECONDS);
  localparam logic [SW-1:0] SEC_LAST   = SW'(LOCK_SECONDS - 1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    LOCKED  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [EW-1:0]   err_nxt;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nxt;
  logic [SW-1:0]   sec_cnt;
  logic [SW-1:0]   sec_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARMED;
      err_count <= '0;
      presc     <= '0;
      sec_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      err_count <= err_nxt;
      presc     <= presc_nxt;
      sec_cnt   <= sec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_count;
    presc_nxt = presc;
    sec_nxt   = sec_cnt;
    locked    = 1'b0;
    fsm_clear = 1'b0;
    case (state)
      ARMED: begin
        // clear_errs wins over fail, and a fail swallows a simultaneous ok
        if (clear_errs) begin
          err_nxt = '0;
        end else if (attempt_fail) begin
          if (err_count >= ERR_LAST) begin
            err_nxt   = ERR_MAX;
            presc_nxt = '0;
            sec_nxt   = '0;
            state_nxt = LOCKED;
          end else begin
            err_nxt = err_count + 1'b1;
          end
        end else if (attempt_ok) begin
          err_nxt = '0;
        end
      end
      LOCKED: begin
        locked  = 1'b1;
        err_nxt = ERR_MAX;
        if (presc == PRESC_LAST) begin
          presc_nxt = '0;
          if (sec_cnt >= SEC_LAST) begin
            sec_nxt   = SEC_MAX;
            state_nxt = RELEASE;
          end else begin
            sec_nxt = sec_cnt + 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      RELEASE: begin
        locked    = 1'b1;
        fsm_clear = 1'b1;
        err_nxt   = '0;
        presc_nxt = '0;
        sec_nxt   = '0;
        state_nxt = ARMED;
      end
      default: begin
        state_nxt = ARMED;
      end
    endcase
  end

  for (genvar i = 0; i < MAX_ERRORS; i++) begin : g_err_led
    assign leds_erros[i] = (err_count > EW'(i));
  end

  for (genvar k = 0; k < LOCK_SECONDS; k++) begin : g_sec_led
    assign leds_segundos[k] = (sec_cnt > SW'(k));
  end

endmodule

// File: tb/tb_safecrack_lockout_ctrl.sv
// tb/tb_safecrack_lockout_ctrl.sv - scoreboard bench with a lockout-timeline reference model
module tb_safecrack_lockout_ctrl;

  localparam int T  = 4;
  localparam int M  = 3;
  localparam int L  = 10;
  localparam int EW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          attempt_fail = 1'b0;
  logic          attempt_ok = 1'b0;
  logic          clear_errs = 1'b0;
  logic          locked;
  logic          fsm_clear;
  logic [EW-1:0] err_count;
  logic [M-1:0]  leds_erros;
  logic [L-1:0]  leds_segundos;

  safecrack_lockout_ctrl #(
    .TICKS_PER_SEC(T),
    .MAX_ERRORS(M),
    .LOCK_SECONDS(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .attempt_fail(attempt_fail),
    .attempt_ok(attempt_ok),
    .clear_errs(clear_errs),
    .locked(locked),
    .fsm_clear(fsm_clear),
    .err_count(err_count),
    .leds_erros(leds_erros),
    .leds_segundos(leds_segundos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit fc;
    int err;
    int le;
    int ls;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: error tally plus the age (in cycles) of the current lockout, -1 when armed.
  int m_errs = 0;
  int m_age  = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit o, input bit c);
    exp_t e;
    int   secs;
    @(negedge clk);
    rst = r;
    attempt_fail = f;
    attempt_ok = o;
    clear_errs = c;
    if (!r) begin
      m_errs = 0;
      m_age  = -1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age > L * T) begin
        m_age  = -1;
        m_errs = 0;
      end
    end else if (c) begin
      m_errs = 0;
    end else if (f) begin
      m_errs++;
      if (m_errs == M) m_age = 0;
    end else if (o) begin
      m_errs = 0;
    end
    secs  = (m_age < 0) ? 0 : ((m_age / T > L) ? L : m_age / T);
    e.lk  = (m_age >= 0);
    e.fc  = (m_age == L * T);
    e.err = m_errs;
    e.le  = (1 << m_errs) - 1;
    e.ls  = (1 << secs) - 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
  endtask

  task automatic lockout();
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", 32'(locked), 32'(e.lk));
        chk("fsm_clear", 32'(fsm_clear), 32'(e.fc));
        chk("err_count", 32'(err_count), e.err);
        chk("leds_erros", 32'(leds_erros), e.le);
        chk("leds_segundos", 32'(leds_segundos), e.ls);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    idle(2);
    drive(1, 1, 0, 0);
    idle(1);
    drive(1, 1, 0, 0);
    idle(1);
    drive(1, 0, 1, 0);
    idle(2);
    lockout();
    idle(10);
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 0, 1);
    drive(1, 1, 1, 1);
    idle(30);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 0, 1);
    idle(2);
    lockout();
    idle(21);
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 1);
    lockout();
    idle(41);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    idle(41);
    idle(2);
    lockout();
    idle(40);
    drive(0, 0, 0, 0);
    idle(3);
    drive(1, 1, 0, 0);
    idle(2);
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0);
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
